mfcc_loop_sequencer: RTL and testbench
======================================

# mfcc_loop_sequencer

Two-level nested-loop controller that sequences the MFCC per-frame datapath: outer loop over frames, inner loop over samples/bins within a frame. Latches loop bounds on `start`, emits one `step_valid` per inner iteration with indices and frame markers, honours a downstream `stall`, and inserts a fixed pipeline-drain gap between frames. Sits between the top-level MFCC control and the windowing/FFT/filterbank stages that consume the indices.

## Interface
- `OUTER_W`, 8, width of the outer (frame) index and bound
- `INNER_W`, 10, width of the inner (sample) index and bound
- `GAP_CYCLES`, 2, idle cycles between frames (0 allowed = back-to-back)

- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a run; sampled only in IDLE
- `outer_last`  in  OUTER_W  last outer index (frames-1); latched on accepted start
- `inner_last`  in  INNER_W  last inner index (samples-1); latched on accepted start
- `stall`  in  1  downstream not ready; blocks the current step
- `busy`  out  1  state != IDLE
- `step_valid`  out  1  current step issued this cycle (RUN & ~stall)
- `inner_idx`  out  INNER_W  current inner index
- `outer_idx`  out  OUTER_W  current outer index
- `frame_start`  out  1  step_valid & inner_idx==0
- `frame_end`  out  1  step_valid & inner_idx==inner_last_q
- `done`  out  1  one-cycle pulse after final step

## Operation
- States: IDLE, RUN, GAP, DONE.
- IDLE: `start`=1 -> latch `outer_last_q`/`inner_last_q`, clear indices, next state RUN. `start` in any other state ignored.
- RUN: `step_valid`=~stall. On a step (step_valid=1):
  - inner_idx != inner_last_q -> inner_idx+1, stay RUN.
  - inner_idx == inner_last_q and outer_idx == outer_last_q -> inner_idx, outer_idx cleared to 0, next DONE.
  - inner_idx == inner_last_q otherwise -> inner_idx=0, outer_idx+1, next GAP (or RUN if GAP_CYCLES=0).
  - stall=1: indices and state hold.
- GAP: gap counter counts GAP_CYCLES cycles, `step_valid`=0, `stall` ignored; then RUN.
- DONE: `done`=1 for exactly one cycle, next IDLE.
- Indices compared against bound before increment; never exceed the bound, so bound = 2^W-1 is legal with no overflow.
- Total steps per run = (outer_last+1)*(inner_last+1). inner_last=0 -> every step has frame_start=frame_end=1. Both bounds 0 -> single step.
- Inputs `outer_last`/`inner_last` changing during a run have no effect.
- `rst` at any time: next edge -> IDLE, indices 0, latched bounds 0, gap counter 0, no `done` pulse.

## Timing
- Reset values: busy=0, step_valid=0, inner_idx=0, outer_idx=0, frame_start=0, frame_end=0, done=0.
- start accepted in cycle 0 -> first step_valid in cycle 1 (one-cycle latency).
- Outputs are combinational from state/index registers; no input-to-output paths except `stall` -> step_valid/frame_start/frame_end.
- done asserts the cycle after the final step; IDLE the cycle after done, so a new start is accepted at done+1.
- Example (outer_last=1, inner_last=2, GAP_CYCLES=2, no stall): steps cycles 1-3, gap 4-5, steps 6-8, done 9, busy 1-9.

## Structure
- Package `mfcc_seq_pkg`: state encoding localparams (IDLE=2'd0, RUN=2'd1, GAP=2'd2, DONE=2'd3) and default widths.
- Sub-module `loop_cnt_sync`: synchronous-reset counter with `clr`, `en`, `last` bound input, `idx` output and combinational `at_last`; instantiated for inner, outer and gap counters.
- Top contains FSM, bound latches and output decode.

## Test plan
- Reset then start with outer_last=1, inner_last=2, no stall -> 6 step_valid pulses at cycles 1-3, 6-8; (outer,inner) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); frame_start at 1,6; frame_end at 3,8; done at 9 only.
- Same run with stall=1 in cycles 2-4 -> index (0,1) held through stall, steps resume cycle 5; total still 6 steps, done shifts by 3 cycles to 12.
- outer_last=0, inner_last=0 -> single step cycle 1 with frame_start=frame_end=1, done cycle 2; start pulsed during cycles 1-2 ignored, busy=0 at cycle 3.
- GAP_CYCLES=0, outer_last=2, inner_last=0 -> steps cycles 1,2,3 back-to-back, outer_idx 0,1,2; done cycle 4.
- inner_last=1023 (INNER_W=10), outer_last=0 -> 1024 steps, inner_idx reaches 1023 without wrap before done; done at cycle 1025.
- rst asserted for one cycle mid-run at (0,1) -> next cycle busy=0, indices 0, no done; subsequent start runs full sequence from (0,0).

Source files
------------

// File: rtl/mfcc_seq_pkg.sv
// Shared definitions for the MFCC frame/sample loop sequencer: state encoding,
// default widths and a counter-width helper.
package mfcc_seq_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StGap  = 2'd2,
      StDone = 2'd3
   } seq_state_e;

   localparam int unsigned DefOuterW    = 8;
   localparam int unsigned DefInnerW    = 10;
   localparam int unsigned DefGapCycles = 2;

   // Width of a counter that must reach n-1; at least one bit so n=0/1 stays legal.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/loop_cnt_sync.sv
// Up-counter with synchronous reset/clear and a combinational at-bound flag.
module loop_cnt_sync #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] last,
   output logic [W-1:0] idx,
   output logic         at_last
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         idx <= '0;
      end else if (en) begin
         idx <= idx + W'(1);
      end
   end

   assign at_last = (idx == last);

endmodule

// File: rtl/mfcc_loop_sequencer.sv
// Two-level frame/sample loop controller issuing one indexed step per inner
// iteration, with downstream stall and a fixed drain gap between frames.
module mfcc_loop_sequencer
   import mfcc_seq_pkg::*;
#(
   parameter int unsigned OUTER_W    = DefOuterW,
   parameter int unsigned INNER_W    = DefInnerW,
   parameter int unsigned GAP_CYCLES = DefGapCycles
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [OUTER_W-1:0] outer_last,
   input  logic [INNER_W-1:0] inner_last,
   input  logic               stall,
   output logic               busy,
   output logic               step_valid,
   output logic [INNER_W-1:0] inner_idx,
   output logic [OUTER_W-1:0] outer_idx,
   output logic               frame_start,
   output logic               frame_end,
   output logic               done
);

   localparam int unsigned     GapW    = cnt_w(GAP_CYCLES);
   localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic            HasGap  = (GAP_CYCLES != 0);

   seq_state_e         state_q;
   logic [OUTER_W-1:0] outer_last_q;
   logic [INNER_W-1:0] inner_last_q;

   logic            start_acc;
   logic            inner_at_last;
   logic            outer_at_last;
   logic            gap_at_last;
   logic [GapW-1:0] gap_idx;
   logic            unused_gap_idx;

   assign start_acc  = (state_q == StIdle) && start;
   assign step_valid = (state_q == StRun) && !stall;

   // Indices wrap to zero on their last value instead of incrementing, so a bound
   // of all-ones never overflows.
   loop_cnt_sync #(.W(INNER_W)) u_inner_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr     (start_acc || (step_valid && inner_at_last)),
      .en      (step_valid && !inner_at_last),
      .last    (inner_last_q),
      .idx     (inner_idx),
      .at_last (inner_at_last)
   );

   loop_cnt_sync #(.W(OUTER_W)) u_outer_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr     (start_acc || (step_valid && inner_at_last && outer_at_last)),
      .en      (step_valid && inner_at_last && !outer_at_last),
      .last    (outer_last_q),
      .idx     (outer_idx),
      .at_last (outer_at_last)
   );

   loop_cnt_sync #(.W(GapW)) u_gap_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr     (state_q != StGap),
      .en      (state_q == StGap),
      .last    (GapLast),
      .idx     (gap_idx),
      .at_last (gap_at_last)
   );

   assign unused_gap_idx = ^gap_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         outer_last_q <= '0;
         inner_last_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  outer_last_q <= outer_last;
                  inner_last_q <= inner_last;
                  state_q      <= StRun;
               end
            end
            StRun: begin
               if (step_valid && inner_at_last) begin
                  if (outer_at_last) begin
                     state_q <= StDone;
                  end else if (HasGap) begin
                     state_q <= StGap;
                  end
               end
            end
            StGap: begin
               if (gap_at_last) begin
                  state_q <= StRun;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign busy        = (state_q != StIdle);
   assign done        = (state_q == StDone);
   assign frame_start = step_valid && (inner_idx == '0);
   assign frame_end   = step_valid && inner_at_last;

endmodule

// File: tb/tb_mfcc_loop_sequencer.sv
// Directed bench for mfcc_loop_sequencer: default-gap instance plus a
// zero-gap instance sharing the same stimulus.
module tb_mfcc_loop_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] outer_last;
   logic [9:0] inner_last;
   logic       stall;

   logic       busy, step_valid, frame_start, frame_end, done;
   logic [9:0] inner_idx;
   logic [7:0] outer_idx;

   logic       g0_busy, g0_step_valid, g0_frame_start, g0_frame_end, g0_done;
   logic [9:0] g0_inner_idx;
   logic [7:0] g0_outer_idx;

   int n_vec = 0;
   int n_err = 0;

   mfcc_loop_sequencer #(.OUTER_W(8), .INNER_W(10), .GAP_CYCLES(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .outer_last  (outer_last),
      .inner_last  (inner_last),
      .stall       (stall),
      .busy        (busy),
      .step_valid  (step_valid),
      .inner_idx   (inner_idx),
      .outer_idx   (outer_idx),
      .frame_start (frame_start),
      .frame_end   (frame_end),
      .done        (done)
   );

   mfcc_loop_sequencer #(.OUTER_W(8), .INNER_W(10), .GAP_CYCLES(0)) dut_g0 (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .outer_last  (outer_last),
      .inner_last  (inner_last),
      .stall       (stall),
      .busy        (g0_busy),
      .step_valid  (g0_step_valid),
      .inner_idx   (g0_inner_idx),
      .outer_idx   (g0_outer_idx),
      .frame_start (g0_frame_start),
      .frame_end   (g0_frame_end),
      .done        (g0_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one cycle, then drive this cycle's inputs; outputs are sampled 2 units after the edge.
   task automatic cyc_in(input logic s, input logic st);
      @(posedge clk);
      #1;
      stall = s;
      start = st;
      #1;
   endtask

   task automatic chk_cyc(input string tag, input logic sv, input int ii, input int oi,
                          input logic fs, input logic fe, input logic dn, input logic bz);
      check_eq({tag, ".step_valid"},  32'(step_valid),  32'(sv));
      check_eq({tag, ".inner_idx"},   32'(inner_idx),   32'(ii));
      check_eq({tag, ".outer_idx"},   32'(outer_idx),   32'(oi));
      check_eq({tag, ".frame_start"}, 32'(frame_start), 32'(fs));
      check_eq({tag, ".frame_end"},   32'(frame_end),   32'(fe));
      check_eq({tag, ".done"},        32'(done),        32'(dn));
      check_eq({tag, ".busy"},        32'(busy),        32'(bz));
   endtask

   task automatic chk_g0(input string tag, input logic sv, input int oi, input logic fs,
                         input logic fe, input logic dn, input logic bz);
      check_eq({tag, ".step_valid"},  32'(g0_step_valid),  32'(sv));
      check_eq({tag, ".outer_idx"},   32'(g0_outer_idx),   32'(oi));
      check_eq({tag, ".inner_idx"},   32'(g0_inner_idx),   32'(0));
      check_eq({tag, ".frame_start"}, 32'(g0_frame_start), 32'(fs));
      check_eq({tag, ".frame_end"},   32'(g0_frame_end),   32'(fe));
      check_eq({tag, ".done"},        32'(g0_done),        32'(dn));
      check_eq({tag, ".busy"},        32'(g0_busy),        32'(bz));
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      start = 1'b0;
      stall = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
   endtask

   // Start outer_last=1, inner_last=2 with no stall; bounds are scrambled after acceptance.
   task automatic run_basic(input string tag);
      outer_last = 8'd1;
      inner_last = 10'd2;
      cyc_in(1'b0, 1'b1);
      cyc_in(1'b0, 1'b0);
      outer_last = 8'd5;
      inner_last = 10'd7;
      chk_cyc({tag, ".c1"},  1, 0, 0, 1, 0, 0, 1);
      cyc_in(1'b0, 1'b0); chk_cyc({tag, ".c2"},  1, 1, 0, 0, 0, 0, 1);
      cyc_in(1'b0, 1'b0); chk_cyc({tag, ".c3"},  1, 2, 0, 0, 1, 0, 1);
      cyc_in(1'b0, 1'b0); chk_cyc({tag, ".c4"},  0, 0, 1, 0, 0, 0, 1);
      cyc_in(1'b0, 1'b0); chk_cyc({tag, ".c5"},  0, 0, 1, 0, 0, 0, 1);
      cyc_in(1'b0, 1'b0); chk_cyc({tag, ".c6"},  1, 0, 1, 1, 0, 0, 1);
      cyc_in(1'b0, 1'b0); chk_cyc({tag, ".c7"},  1, 1, 1, 0, 0, 0, 1);
      cyc_in(1'b0, 1'b0); chk_cyc({tag, ".c8"},  1, 2, 1, 0, 1, 0, 1);
      cyc_in(1'b0, 1'b0); chk_cyc({tag, ".c9"},  0, 0, 0, 0, 0, 1, 1);
      cyc_in(1'b0, 1'b0); chk_cyc({tag, ".c10"}, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      stall      = 1'b0;
      outer_last = '0;
      inner_last = '0;

      do_reset();
      chk_cyc("reset", 0, 0, 0, 0, 0, 0, 0);

      run_basic("basic");

      // Stall cycles 2-4 holds (0,1); done moves to cycle 12.
      do_reset();
      outer_last = 8'd1;
      inner_last = 10'd2;
      cyc_in(1'b0, 1'b1);
      cyc_in(1'b0, 1'b0); chk_cyc("stall.c1",  1, 0, 0, 1, 0, 0, 1);
      cyc_in(1'b1, 1'b0); chk_cyc("stall.c2",  0, 1, 0, 0, 0, 0, 1);
      cyc_in(1'b1, 1'b0); chk_cyc("stall.c3",  0, 1, 0, 0, 0, 0, 1);
      cyc_in(1'b1, 1'b0); chk_cyc("stall.c4",  0, 1, 0, 0, 0, 0, 1);
      cyc_in(1'b0, 1'b0); chk_cyc("stall.c5",  1, 1, 0, 0, 0, 0, 1);
      cyc_in(1'b0, 1'b0); chk_cyc("stall.c6",  1, 2, 0, 0, 1, 0, 1);
      cyc_in(1'b1, 1'b0); chk_cyc("stall.c7",  0, 0, 1, 0, 0, 0, 1);
      cyc_in(1'b1, 1'b0); chk_cyc("stall.c8",  0, 0, 1, 0, 0, 0, 1);
      cyc_in(1'b0, 1'b0); chk_cyc("stall.c9",  1, 0, 1, 1, 0, 0, 1);
      cyc_in(1'b0, 1'b0); chk_cyc("stall.c10", 1, 1, 1, 0, 0, 0, 1);
      cyc_in(1'b0, 1'b0); chk_cyc("stall.c11", 1, 2, 1, 0, 1, 0, 1);
      cyc_in(1'b0, 1'b0); chk_cyc("stall.c12", 0, 0, 0, 0, 0, 1, 1);
      cyc_in(1'b0, 1'b0); chk_cyc("stall.c13", 0, 0, 0, 0, 0, 0, 0);

      // Single-step run; start held high through cycles 1-2 must not restart.
      do_reset();
      outer_last = 8'd0;
      inner_last = 10'd0;
      cyc_in(1'b0, 1'b1);
      cyc_in(1'b0, 1'b1); chk_cyc("single.c1", 1, 0, 0, 1, 1, 0, 1);
      cyc_in(1'b0, 1'b1); chk_cyc("single.c2", 0, 0, 0, 0, 0, 1, 1);
      cyc_in(1'b0, 1'b0); chk_cyc("single.c3", 0, 0, 0, 0, 0, 0, 0);
      cyc_in(1'b0, 1'b0); chk_cyc("single.c4", 0, 0, 0, 0, 0, 0, 0);

      // Zero-gap instance: outer_last=2, inner_last=0 runs back-to-back.
      do_reset();
      outer_last = 8'd2;
      inner_last = 10'd0;
      cyc_in(1'b0, 1'b1);
      cyc_in(1'b0, 1'b0); chk_g0("nogap.c1", 1, 0, 1, 1, 0, 1);
      cyc_in(1'b0, 1'b0); chk_g0("nogap.c2", 1, 1, 1, 1, 0, 1);
      cyc_in(1'b0, 1'b0); chk_g0("nogap.c3", 1, 2, 1, 1, 0, 1);
      cyc_in(1'b0, 1'b0); chk_g0("nogap.c4", 0, 0, 0, 0, 1, 1);
      cyc_in(1'b0, 1'b0); chk_g0("nogap.c5", 0, 0, 0, 0, 0, 0);

      // Full-range inner bound: 1024 steps, no wrap before done at cycle 1025.
      do_reset();
      outer_last = 8'd0;
      inner_last = 10'd1023;
      cyc_in(1'b0, 1'b1);
      for (int c = 1; c <= 1024; c++) begin
         cyc_in(1'b0, 1'b0);
         check_eq($sformatf("wide.c%0d.step_valid", c), 32'(step_valid), 32'd1);
         check_eq($sformatf("wide.c%0d.inner_idx", c), 32'(inner_idx), 32'(c - 1));
         check_eq($sformatf("wide.c%0d.done", c), 32'(done), 32'd0);
      end
      check_eq("wide.c1024.frame_end", 32'(frame_end), 32'd1);
      check_eq("wide.c1024.outer_idx", 32'(outer_idx), 32'd0);
      cyc_in(1'b0, 1'b0); chk_cyc("wide.c1025", 0, 0, 0, 0, 0, 1, 1);
      cyc_in(1'b0, 1'b0); chk_cyc("wide.c1026", 0, 0, 0, 0, 0, 0, 0);

      // Reset mid-run at (0,1), then a fresh run starts from (0,0).
      do_reset();
      outer_last = 8'd1;
      inner_last = 10'd2;
      cyc_in(1'b0, 1'b1);
      cyc_in(1'b0, 1'b0); chk_cyc("midrst.c1", 1, 0, 0, 1, 0, 0, 1);
      cyc_in(1'b0, 1'b0); chk_cyc("midrst.c2", 1, 1, 0, 0, 0, 0, 1);
      rst = 1'b1;
      cyc_in(1'b0, 1'b0);
      rst = 1'b0;
      #1;
      chk_cyc("midrst.c3", 0, 0, 0, 0, 0, 0, 0);
      cyc_in(1'b0, 1'b0); chk_cyc("midrst.c4", 0, 0, 0, 0, 0, 0, 0);
      run_basic("rerun");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
